// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS-subset core (lui, addi, add, lw, sw,
//   beq, j, sllv). Steps one instruction at a time through a shared datapath
//   and handshakes a variable-latency memory with a timeout watchdog.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   run                keep issuing instructions; 0 stops at the next boundary
//   opcode, func       IR[31:26], IR[5:0]; stable from DECODE to next FETCH
//   zero               ALU zero flag, valid in EXEC
//   mem_ready          memory completes the current request this cycle
//   imem_req, ir_we    instruction fetch request / IR load strobe
//   pc_we, pc_src      PC update strobe and source (00 +4, 01 branch, 10 jump)
//   c1, c2, c3, cA     datapath selects and one-hot ALU op
//   dmem_req, dmem_we  data memory request / write
//   reg_we             register-file write strobe
//   state              current state encoding (debug)
//   halted             reserved instruction trapped (sticky)
//   timeout_err        memory handshake timed out (sticky)
//   retired            completed instruction count, wraps
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for run
// FETCH  | instruction fetch, wait for mem_ready
// DECODE | classify instruction; j completes here
// EXEC   | ALU operation; beq completes here
// MEM    | data memory access, wait for mem_ready; sw completes here
// WB     | register write-back; completes lui/addi/add/sllv/lw
// HALT   | reserved instruction trapped, held until reset
// ERR    | memory timeout, held until reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic [3:0]       cA,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        T_NONE, T_LUI, T_ADDI, T_ADD, T_LW, T_SW, T_BEQ, T_J, T_SLLV
    } ityp_t;

    state_t           cur, nxt, nxt_instr;
    ityp_t            ityp, dec_typ;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_last;
    logic             retire;
    logic [3:0]       alu_ca;
    logic             alu_imm;

    always_comb begin
        dec_typ = T_NONE;
        case (opcode)
            6'b001111: dec_typ = T_LUI;
            6'b001000: dec_typ = T_ADDI;
            6'b100011: dec_typ = T_LW;
            6'b101011: dec_typ = T_SW;
            6'b000100: dec_typ = T_BEQ;
            6'b000010: dec_typ = T_J;
            6'b000000: begin
                if (func == 6'b100000)      dec_typ = T_ADD;
                else if (func == 6'b000100) dec_typ = T_SLLV;
            end
            default:   dec_typ = T_NONE;
        endcase
    end

    // ALU op and immediate-B select shared by EXEC and WB
    always_comb begin
        alu_ca  = 4'b0000;
        alu_imm = 1'b0;
        case (ityp)
            T_LUI:              begin alu_ca = 4'b0001; alu_imm = 1'b1; end
            T_ADDI, T_LW, T_SW: begin alu_ca = 4'b0010; alu_imm = 1'b1; end
            T_ADD:              alu_ca = 4'b0100;
            T_SLLV:             alu_ca = 4'b1000;
            default:            ;
        endcase
    end

    // Ready in the limit cycle still completes; only a miss there trips ERR
    assign tmo_last  = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
    assign nxt_instr = run ? FETCH : IDLE;
    assign state     = cur;

    always_comb begin
        nxt         = cur;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        c1          = 1'b0;
        c2          = 1'b0;
        c3          = 1'b0;
        cA          = 4'b0000;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        halted      = 1'b0;
        timeout_err = 1'b0;
        retire      = 1'b0;
        case (cur)
            IDLE: if (run) nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end else if (tmo_last) begin
                    nxt = ERR;
                end
            end
            DECODE: begin
                // j completes from the raw decode, before the type is latched
                if (dec_typ == T_NONE) begin
                    nxt = HALT;
                end else if (dec_typ == T_J) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                    retire = 1'b1;
                    nxt    = nxt_instr;
                end else begin
                    nxt = EXEC;
                end
            end
            EXEC: begin
                cA = alu_ca;
                c1 = alu_imm;
                case (ityp)
                    T_BEQ: begin
                        pc_we  = 1'b1;
                        pc_src = zero ? 2'b01 : 2'b00;
                        retire = 1'b1;
                        nxt    = nxt_instr;
                    end
                    T_LW, T_SW: nxt = MEM;
                    default:    nxt = WB;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (ityp == T_SW);
                c1       = 1'b1;
                cA       = 4'b0010;
                if (mem_ready) begin
                    if (ityp == T_SW) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = nxt_instr;
                    end else begin
                        nxt = WB;
                    end
                end else if (tmo_last) begin
                    nxt = ERR;
                end
            end
            WB: begin
                reg_we = 1'b1;
                cA     = alu_ca;
                c1     = alu_imm;
                c2     = (ityp == T_ADD) || (ityp == T_SLLV);
                c3     = (ityp == T_LW);
                pc_we  = 1'b1;
                retire = 1'b1;
                nxt    = nxt_instr;
            end
            HALT:    halted = 1'b1;
            ERR:     timeout_err = 1'b1;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= IDLE;
            ityp    <= T_NONE;
            tmo_cnt <= '0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) ityp <= dec_typ;
            // Any state change clears the watchdog, so each FETCH/MEM starts fresh
            if (nxt != cur)
                tmo_cnt <= '0;
            else if ((cur == FETCH || cur == MEM) && !mem_ready)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

endmodule
